// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
//
// Registered 1-to-N valid/ready stream demultiplexer. Each accepted input
// word is routed to one of N = 2**CH_BITS channels, picked either by an
// explicit select (addressed mode) or by an internal rotating pointer
// (round-robin mode). Every channel owns a one-entry output register, so a
// stalled consumer only blocks words aimed at its own channel.
//
// Parameters:
//   WIDTH    data word width in bits
//   CH_BITS  select width; channel count N = 2**CH_BITS
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mode       0 = addressed (use sel), 1 = round-robin (ignore sel)
//   sel        target channel in addressed mode
//   in_valid   producer has a word
//   in_data    input word
//   in_ready   block accepts the word this cycle
//   out_valid  bit k: channel k register holds a word
//   out_data   channel k word at bits [k*WIDTH +: WIDTH]
//   out_ready  bit k: consumer k takes its word this cycle
//   rr_ptr     current round-robin pointer (status)
// ----------------------------------------------------------------------------
module stream_demux #(
   parameter int WIDTH   = 8,
   parameter int CH_BITS = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mode,
   input  logic [CH_BITS-1:0]            sel,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   output logic [(2**CH_BITS)-1:0]       out_valid,
   output logic [(2**CH_BITS)*WIDTH-1:0] out_data,
   input  logic [(2**CH_BITS)-1:0]       out_ready,
   output logic [CH_BITS-1:0]            rr_ptr
);

   localparam int N = 2**CH_BITS;

   logic [CH_BITS-1:0] target;
   logic               accept;

   // The target depends only on mode/sel/pointer, and readiness only on the
   // target's own register, so in_valid never feeds back into in_ready.
   assign target   = mode ? rr_ptr : sel;
   assign in_ready = ~out_valid[target] | out_ready[target];
   assign accept   = in_valid & in_ready;

   // Per-channel one-entry registers. A load to the target wins over its
   // drain (valid stays 1); every other channel just drains on its own.
   // NOTE: data registers are reset too, because out_data must read as zero
   // right after reset, not merely be "invalid".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (accept && (target == CH_BITS'(k))) begin
               out_valid[k]                <= 1'b1;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
            end else if (out_valid[k] && out_ready[k]) begin
               // Data is left untouched so stale contents stay stable.
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   // The pointer only moves on a round-robin accept, so a full channel makes
   // it wait there instead of skipping ahead. Natural overflow wraps N-1 to 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept && mode) begin
         rr_ptr <= rr_ptr + CH_BITS'(1);
      end
   end

endmodule
